// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared definitions for the iterative restoring divider:
//             FSM state encoding, default operand width and counter width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_div_if
//  Purpose  : Request/result bundle of the divide unit.
//  Ports    : start, a, b, is_signed  - request side (master drives)
//             busy, done, q, r, dz     - result side (slave drives)
//  Revision : 1.0  initial release
// ============================================================================
interface booth_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, q, r, dz
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One restoring-division step (combinational). Shifts the next
//             dividend bit into the partial remainder and subtracts the
//             divisor if it fits, shifting the resulting quotient bit in.
//  Ports    : rem, quo, divisor (in)  - current remainder, dividend/quotient
//                                       shift register, divisor magnitude
//             rem_nxt, quo_nxt (out)  - values after this step
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic [WIDTH-1:0] quo,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_nxt,
    output logic      [WIDTH-1:0] quo_nxt
);
    // rem < divisor always holds, so the WIDTH+1-bit difference never
    // wraps and its MSB is a valid sign bit.
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
        if (!w_trial[WIDTH]) begin
            rem_nxt = w_trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule
`default_nettype wire

// File: rtl/booth_div.sv
`default_nettype none
// ============================================================================
//  Module   : booth_div
//  Purpose  : Iterative WIDTH-cycle restoring divider, signed or unsigned,
//             fixed latency. Quotient truncates toward zero, remainder takes
//             the dividend's sign. Divide-by-zero flags dz, q=all ones, r=a.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - booth_div_if slave (start/a/b/is_signed in,
//                    busy/done/q/r/dz out)
//  Revision : 1.0  initial release
// ============================================================================
module booth_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst,
    booth_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;       // raw captured dividend
    logic [WIDTH-1:0] r_b;       // raw captured divisor
    logic             r_signed;
    logic [WIDTH-1:0] r_div;     // divisor magnitude
    logic [WIDTH-1:0] r_quo;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_rem;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_div),
        .rem_nxt (w_rem_nxt),
        .quo_nxt (w_quo_nxt)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_next = PREP;
            end
            PREP: begin
                w_busy = 1'b1;
                w_next = ITER;
            end
            ITER: begin
                w_busy = 1'b1;
                if (r_cnt == C_CNT_LAST) w_next = FIX;
            end
            FIX: begin
                w_busy = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                w_done   = 1'b1;
                w_accept = bus.start;
                if (bus.start) w_next = PREP;
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_div    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_signed <= bus.is_signed;
                r_dz     <= 1'b0;
            end
            case (r_state)
                PREP: begin
                    r_div  <= (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
                    r_quo  <= (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
                    r_rem  <= '0;
                    r_qneg <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_rneg <= r_signed & r_a[WIDTH-1];
                    r_cnt  <= '0;
                end
                ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    // Zero divisor overrides the iteration result and skips
                    // sign fix-up; the overflow case (MIN / -1) needs no
                    // special handling since negation wraps mod 2^WIDTH.
                    if (r_b == '0) begin
                        r_dz <= 1'b1;
                        r_q  <= '1;
                        r_r  <= r_a;
                    end else begin
                        r_q  <= r_qneg ? -r_quo : r_quo;
                        r_r  <= r_rneg ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.dz   = r_dz;
endmodule
`default_nettype wire
